// File: rtl/spec_pulse_acc_if.sv
// Spectrum input stream and accumulated-bin output stream of spec_pulse_acc.
// slave = accumulator side, master = source/sink side.
interface spec_pulse_acc_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 9
);
    logic              spec_valid_i;
    logic [DATA_W-1:0] spec_data_i;
    logic              acc_valid_o;
    logic [ACC_W-1:0]  acc_data_o;
    logic [ADDR_W-1:0] acc_index_o;

    modport slave  (input  spec_valid_i, spec_data_i,
                    output acc_valid_o, acc_data_o, acc_index_o);
    modport master (output spec_valid_i, spec_data_i,
                    input  acc_valid_o, acc_data_o, acc_index_o);
endinterface

// File: rtl/spec_pulse_acc.sv
// Multi-pulse power-spectrum accumulator: per-bin read-modify-write over N pulses,
// saturating sums emitted on the final pulse with a fixed 2-cycle latency.
module spec_pulse_acc #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      acc_num_i,
    input  logic             abort_i,
    spec_pulse_acc_if.slave  bus,
    output logic             acc_done_o,
    output logic             busy_o,
    output logic             overflow_o
);
    localparam int BINS = 1 << ADDR_W;

    typedef enum logic {IDLE, ACC} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [15:0]       pulse_q, pulse_d, nlast_q, nlast_d;

    logic              beat, frame_start, beat_first, beat_last;
    logic [ADDR_W-1:0] beat_addr;
    logic [15:0]       beat_pulse, beat_nlast;

    // vld_pipe[1]: beat in add/write stage, vld_pipe[2]: output register
    logic [2:1]        vld_pipe;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              s1_first, s1_last;

    logic [ACC_W-1:0]  mem [BINS];
    logic [ACC_W-1:0]  ram_q, sum;
    logic [ACC_W:0]    sum_ext;
    logic              sat, wr_en;

    logic [ACC_W-1:0]  acc_data_q;
    logic [ADDR_W-1:0] acc_index_q;
    logic              acc_done_q, ovf_q;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        pulse_d     = pulse_q;
        nlast_d     = nlast_q;
        frame_start = 1'b0;
        beat_addr   = bin_q;
        beat_pulse  = pulse_q;
        beat_nlast  = nlast_q;
        beat        = bus.spec_valid_i & ~abort_i;
        if (abort_i) begin
            state_d = IDLE;
        end else if (beat) begin
            if (state_q == IDLE) begin
                // First beat of a frame is bin 0 of pulse 0; N=0 behaves as N=1.
                frame_start = 1'b1;
                nlast_d     = (acc_num_i == 16'd0) ? 16'd0 : acc_num_i - 16'd1;
                beat_addr   = '0;
                beat_pulse  = 16'd0;
                beat_nlast  = nlast_d;
            end
            bin_d   = beat_addr + ADDR_W'(1);
            pulse_d = (&beat_addr) ? beat_pulse + 16'd1 : beat_pulse;
            state_d = (beat_pulse == beat_nlast && (&beat_addr)) ? IDLE : ACC;
        end
        beat_first = (beat_pulse == 16'd0);
        beat_last  = (beat_pulse == beat_nlast);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            bin_q   <= '0;
            pulse_q <= '0;
            nlast_q <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            pulse_q <= pulse_d;
            nlast_q <= nlast_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_pipe <= '0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            vld_pipe[1] <= beat;
            vld_pipe[2] <= vld_pipe[1] & s1_last & ~abort_i;
            s1_addr     <= beat_addr;
            s1_data     <= bus.spec_data_i;
            s1_first    <= beat_first;
            s1_last     <= beat_last;
        end
    end

    // Pulse 0 overwrites the bin, so stale contents never need clearing.
    assign sum_ext = {1'b0, ram_q} + (ACC_W+1)'(s1_data);
    assign sat     = ~s1_first & sum_ext[ACC_W];
    assign sum     = s1_first ? ACC_W'(s1_data) : (sat ? '1 : sum_ext[ACC_W-1:0]);
    assign wr_en   = vld_pipe[1] & ~s1_last;

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[s1_addr] <= sum;
        ram_q <= mem[beat_addr];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            acc_data_q  <= '0;
            acc_index_q <= '0;
            acc_done_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_done_q <= vld_pipe[1] & s1_last & (&s1_addr) & ~abort_i;
            if (vld_pipe[1] & s1_last) begin
                acc_data_q  <= sum;
                acc_index_q <= s1_addr;
            end
            if (frame_start) ovf_q <= 1'b0;
            if (vld_pipe[1] & sat & ~abort_i) ovf_q <= 1'b1;
        end
    end

    assign bus.acc_valid_o = vld_pipe[2];
    assign bus.acc_data_o  = acc_data_q;
    assign bus.acc_index_o = acc_index_q;
    assign acc_done_o      = acc_done_q;
    assign busy_o          = (state_q == ACC);
    assign overflow_o      = ovf_q;
endmodule

// File: tb/tb_spec_pulse_acc.sv
// Directed bench for spec_pulse_acc with 8 bins and a 33-bit accumulator.
module tb_spec_pulse_acc;
    localparam int DW = 32, AW = 33, XW = 3, BINS = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] acc_num_i = '0;
    logic        acc_done_o, busy_o, overflow_o;

    spec_pulse_acc_if #(.DATA_W(DW), .ACC_W(AW), .ADDR_W(XW)) bus ();

    spec_pulse_acc #(.DATA_W(DW), .ACC_W(AW), .ADDR_W(XW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .acc_num_i  (acc_num_i),
        .abort_i    (abort_i),
        .bus        (bus),
        .acc_done_o (acc_done_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int n_run = 0, n_fail = 0;
    int cyc = 0, stray_done = 0;
    int q_idx[$], q_cyc[$], q_done[$], exp_cyc_q[$];
    logic [63:0] q_dat[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.acc_valid_o === 1'b1) begin
            q_idx.push_back(int'(bus.acc_index_o));
            q_dat.push_back(64'(bus.acc_data_o));
            q_done.push_back(int'(acc_done_o));
            q_cyc.push_back(cyc);
        end else if (acc_done_o === 1'b1) begin
            stray_done++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dat_of(input int mode, input int p, input int b);
        case (mode)
            0:       return 32'(b + 1);
            1:       return 32'hFFFF_FFFF;
            2:       return (p == 0) ? 32'(3 * (b + 1)) : 32'(5 * (b + 1));
            default: return 32'(b + 7);
        endcase
    endfunction

    // Hand-derived results for each data pattern.
    function automatic logic [63:0] exp_of(input int mode, input int n, input int b);
        case (mode)
            0:       return 64'(n * (b + 1));
            1:       return (n <= 1) ? 64'h0_FFFF_FFFF : 64'h1_FFFF_FFFF;
            2:       return 64'(8 * (b + 1));
            default: return 64'(b + 7);
        endcase
    endfunction

    task automatic send_frame(input int n, input int mode, input int gap_max, input int abort_at);
        int ne = (n == 0) ? 1 : n;
        int k = 0;
        acc_num_i = 16'(n);
        for (int p = 0; p < ne; p++) begin
            for (int b = 0; b < BINS; b++) begin
                bus.spec_valid_i = 1'b1;
                bus.spec_data_i  = dat_of(mode, p, b);
                if (k == abort_at) begin
                    abort_i = 1'b1;
                    tick();
                    abort_i = 1'b0;
                    bus.spec_valid_i = 1'b0;
                    chk("abort_busy", 64'(busy_o), 64'd0);
                    return;
                end
                if (p == ne - 1) exp_cyc_q.push_back(cyc);
                tick();
                bus.spec_valid_i = 1'b0;
                if (k == 0) begin
                    chk("start_busy", 64'(busy_o), 64'd1);
                    chk("start_ovf", 64'(overflow_o), 64'd0);
                    acc_num_i = 16'd7;
                end
                if (p == ne - 1 && b == BINS - 1) chk("end_busy", 64'(busy_o), 64'd0);
                k++;
                if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            end
        end
    endtask

    task automatic check_frame(input string tag, input int mode, input int n);
        int t = 0;
        int e;
        while (q_dat.size() < BINS && t < 100) begin
            tick();
            t++;
        end
        chk({tag, "_cnt"}, 64'(q_dat.size() >= BINS), 64'd1);
        for (int b = 0; b < BINS; b++) begin
            if (q_dat.size() == 0) break;
            e = (exp_cyc_q.size() > 0) ? exp_cyc_q.pop_front() : -100;
            chk($sformatf("%s_idx%0d", tag, b), 64'(q_idx.pop_front()), 64'(b));
            chk($sformatf("%s_dat%0d", tag, b), q_dat.pop_front(), exp_of(mode, n, b));
            chk($sformatf("%s_done%0d", tag, b), 64'(q_done.pop_front()), 64'(b == BINS - 1));
            chk($sformatf("%s_lat%0d", tag, b), 64'(q_cyc.pop_front() - e), 64'd2);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"}, 64'(bus.acc_valid_o), 64'd0);
        chk({tag, "_data"},  64'(bus.acc_data_o),  64'd0);
        chk({tag, "_index"}, 64'(bus.acc_index_o), 64'd0);
        chk({tag, "_done"},  64'(acc_done_o),      64'd0);
        chk({tag, "_busy"},  64'(busy_o),          64'd0);
        chk({tag, "_ovf"},   64'(overflow_o),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.spec_valid_i = 1'b0;
        bus.spec_data_i  = '0;
        tick();
        tick();
        chk_reset_outs("rst");
        rst_i = 1'b1;
        tick();

        // N=4, data = bin+1, acc_num_i changed mid-frame
        send_frame(4, 0, 0, -1);
        check_frame("n4", 0, 4);

        // Single-pulse frames, N=0 and N=1
        send_frame(0, 1, 0, -1);
        check_frame("n0", 1, 0);
        send_frame(1, 1, 0, -1);
        check_frame("n1", 1, 1);

        // Saturation at 2^33-1, sticky until next frame start
        send_frame(3, 1, 0, -1);
        check_frame("sat", 1, 3);
        chk("ovf_set", 64'(overflow_o), 64'd1);
        repeat (3) tick();
        chk("ovf_hold", 64'(overflow_o), 64'd1);

        // Random gaps, N=2 (start_ovf inside confirms overflow clear)
        send_frame(2, 0, 3, -1);
        check_frame("gap", 0, 2);

        // Abort at pulse 1 bin 3 of an N=4 frame
        send_frame(4, 2, 0, 11);
        repeat (5) tick();
        chk("abort_outs", 64'(q_dat.size()), 64'd0);
        chk("abort_ovf", 64'(overflow_o), 64'd0);
        exp_cyc_q.delete();
        send_frame(2, 2, 0, -1);
        check_frame("post_abort", 2, 2);

        // Reset mid-frame, then back-to-back frames
        acc_num_i = 16'd2;
        for (int b = 0; b < 5; b++) begin
            bus.spec_valid_i = 1'b1;
            bus.spec_data_i  = 32'(b + 100);
            tick();
            bus.spec_valid_i = 1'b0;
        end
        rst_i = 1'b0;
        tick();
        chk_reset_outs("mid_rst");
        rst_i = 1'b1;
        send_frame(1, 3, 0, -1);
        send_frame(2, 0, 0, -1);
        check_frame("b2b_a", 3, 1);
        check_frame("b2b_b", 0, 2);

        repeat (4) tick();
        chk("stray_done", 64'(stray_done), 64'd0);
        chk("leftover", 64'(q_dat.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/spec_pulse_acc.md
SPEC_PULSE_ACC -- requirements
Module: spec_pulse_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning unsigned power-spectrum input width.
REQ-002 SHALL have parameter ACC_W, default 40, meaning accumulator width; ACC_W >= DATA_W.
REQ-003 SHALL have parameter ADDR_W, default 9, meaning bin-index width; BINS = 2^ADDR_W (default 512), BINS >= 2.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning reset; synchronous and active-low.
REQ-006 SHALL have port acc_num_i, input, 16, meaning the number of pulses per frame; latched at frame start.
REQ-007 SHALL have port abort_i, input, 1, meaning synchronous frame abort.
REQ-008 SHALL have port spec_valid_i, input, 1, meaning the input beat is valid.
REQ-009 SHALL have port spec_data_i, input, DATA_W, meaning one spectrum bin value.
REQ-010 SHALL have port acc_valid_o, output, 1, meaning the accumulated bin is valid.
REQ-011 SHALL have port acc_data_o, output, ACC_W, meaning the accumulated bin value.
REQ-012 SHALL have port acc_index_o, output, ADDR_W, meaning the bin index of acc_data_o.
REQ-013 SHALL have port acc_done_o, output, 1, meaning a one-cycle frame-complete strobe.
REQ-014 SHALL have port busy_o, output, 1, meaning a frame is in progress.
REQ-015 SHALL have port overflow_o, output, 1, meaning a sticky saturation flag for the current or last frame.

Function
REQ-016 SHALL have states IDLE and ACC; busy_o = (state == ACC).
REQ-017 In IDLE, a valid beat SHALL start a frame: latch N = acc_num_i (0 treated as 1), clear overflow_o, set bin_cnt = 0 and pulse_cnt = 0, go to ACC, and process the beat as bin 0 of pulse 0.
REQ-018 Each valid beat SHALL be assigned the address bin_cnt; bin_cnt SHALL increment per beat and wrap BINS-1 -> 0; on wrap, pulse_cnt SHALL increment.
REQ-019 Input beats need not be contiguous; gaps SHALL not advance any counter.
REQ-020 Storage SHALL be one BINS x ACC_W RAM with a 1-cycle registered read; bins SHALL be updated by read-modify-write in a 2-stage pipeline (read at beat cycle, add/write next cycle).
REQ-021 On pulse 0, the RAM SHALL be written with the zero-extended input without reading, so no RAM clear is needed.
REQ-022 On pulses 1..N-2, the RAM SHALL be written with sum = RAM + input.
REQ-023 On pulse N-1, sum SHALL be presented on acc_data_o with acc_valid_o = 1 and acc_index_o = bin, exactly 2 cycles after the beat; this pulse SHALL not need RAM writeback.
REQ-024 When N = 1, the output SHALL equal the zero-extended input, at 2-cycle latency.
REQ-025 Sums SHALL saturate at 2^ACC_W-1, and any saturation SHALL set overflow_o until the next frame start or reset.
REQ-026 acc_done_o SHALL pulse together with the acc_valid_o of bin BINS-1 of pulse N-1; the state SHALL return to IDLE on the cycle of that last input beat.
REQ-027 A valid beat arriving on the cycle after the last beat SHALL start a new frame; the in-flight pipeline SHALL complete unaffected.
REQ-028 abort_i SHALL force IDLE, flush pipeline valids (no acc_valid_o or acc_done_o for the aborted frame), and leave overflow_o unchanged; abort_i with a simultaneous spec_valid_i SHALL discard that beat.
REQ-029 acc_num_i changes during ACC SHALL have no effect.

Reset
REQ-030 While rst_i = 0 at a clock edge, the block SHALL set state IDLE, counters 0, pipeline valids 0, acc_valid_o 0, acc_data_o 0, acc_index_o 0, acc_done_o 0, busy_o 0, and overflow_o 0.
REQ-031 Reset mid-frame SHALL discard the frame, and the next valid beat after release SHALL start a fresh frame.
REQ-032 RAM contents SHALL not be reset.

Verification
REQ-033 A bench SHALL cover: ADDR_W=3, N=4, data = index+1 contiguous -> on pulse 3, acc_data_o = 4*(i+1) for i=0..7, latency 2, and acc_done_o with index 7.
REQ-034 A bench SHALL cover: N=0 and N=1 with data 0xFFFFFFFF -> output 0x00FFFFFFFF per bin after a single pulse.
REQ-035 A bench SHALL cover: DATA_W=32, ACC_W=33, N=3, all data 0xFFFFFFFF -> output 0x1FFFFFFFF saturated, and overflow_o = 1 until the next frame start.
REQ-036 A bench SHALL cover: random 0-3 cycle gaps between beats, N=2 -> sums identical to the contiguous case.
REQ-037 A bench SHALL cover: abort_i at pulse 1 bin 3 -> no outputs and busy_o = 0 next cycle; a new N=2 frame then yields correct sums without a RAM clear.
REQ-038 A bench SHALL cover: rst_i = 0 for one cycle mid-frame, then back-to-back frames with no idle cycle -> all outputs 0 during reset, and both subsequent frames correct.
